// File: rtl/jpeg_zz_pkg.sv
// Shared constants for the zigzag reorder buffer: JPEG zigzag tables, widths, read FSM states.
package jpeg_zz_pkg;

  localparam int unsigned COEF_W   = 8;
  localparam int unsigned BLK_SIZE = 64;
  localparam int unsigned ROWS     = 8;
  localparam int unsigned COL_W    = ROWS * COEF_W;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned NZ_W     = 7;

  // zigzag position -> raster index (row*8+col)
  localparam logic [ADDR_W-1:0] ZZ [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // raster index -> zigzag position
  localparam logic [ADDR_W-1:0] INV_ZZ [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/zigzag_bank.sv
// One 8x8 coefficient bank: whole-column write port, single raster-addressed read port.
module zigzag_bank
  import jpeg_zz_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [CNT_W-1:0]    wcol,
  input  logic [COL_W-1:0]    wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [COEF_W-1:0]   rdata_c
);

  logic [COEF_W-1:0] mem [BLK_SIZE];

  // Column write: row r of the column lands at raster index r*8+wcol; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        mem[{3'(r), wcol}] <= wdata[(COL_W-1-COEF_W*r) -: COEF_W];
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/zigzag_buffer.sv
// Ping-pong column-in / zigzag-out reorder buffer for quantized 8x8 blocks.
// Optional feature macro: ZIGZAG_LAST_NZ_EN (adds out_last_nz, last-nonzero tracking).
module zigzag_buffer
  import jpeg_zz_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COL_W-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [COEF_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_first,
`ifdef ZIGZAG_LAST_NZ_EN
  output logic [NZ_W-1:0]    out_last_nz,
`endif
  output logic               out_last
);

  logic [CNT_W-1:0]  wcol;
  logic              wsel;
  logic              rsel, rsel_d;
  logic [1:0]        full;
  logic [ADDR_W-1:0] rpos, rpos_d, nxt_pos;
  rd_state_e         state, state_d;
  logic              accept, out_hs, wr_done, rd_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [COEF_W-1:0] rdata0, rdata1, bank_rdata;
  logic [COEF_W-1:0] data_d;
  logic              valid_d, first_d, last_d;

  assign in_ready   = !full[wsel];
  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign wr_done    = accept && (wcol == 3'd7);
  assign rd_done    = (state == RD_STREAM) && out_hs && (rpos == 6'd63);
  assign nxt_pos    = 6'(rpos + 6'd1);
  assign rd_addr    = (state == RD_IDLE) ? ZZ[0] : ZZ[nxt_pos];
  assign bank_rdata = rsel ? rdata1 : rdata0;

  zigzag_bank u_bank0 (
    .clk     (clk),
    .we      (accept && !wsel),
    .wcol    (wcol),
    .wdata   (in_data),
    .raddr   (rd_addr),
    .rdata_c (rdata0)
  );

  zigzag_bank u_bank1 (
    .clk     (clk),
    .we      (accept && wsel),
    .wcol    (wcol),
    .wdata   (in_data),
    .raddr   (rd_addr),
    .rdata_c (rdata1)
  );

  // Write side: column counter and bank pointer advance per accepted column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcol <= '0;
      wsel <= 1'b0;
    end else if (accept) begin
      wcol <= 3'(wcol + 3'd1);
      if (wcol == 3'd7) wsel <= ~wsel;
    end
  end

  // Bank full flags: set by the writer, cleared by the reader; the two always target different banks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= '0;
    end else begin
      if (wr_done) full[wsel] <= 1'b1;
      if (rd_done) full[rsel] <= 1'b0;
    end
  end

  // Read FSM next-state and next-output logic.
  always_comb begin
    state_d = state;
    rpos_d  = rpos;
    rsel_d  = rsel;
    valid_d = out_valid;
    data_d  = out_data;
    first_d = out_first;
    last_d  = out_last;
    case (state)
      RD_IDLE: begin
        if (full[rsel]) begin
          data_d  = bank_rdata;
          valid_d = 1'b1;
          first_d = 1'b1;
          last_d  = 1'b0;
          rpos_d  = '0;
          state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (out_hs) begin
          if (rpos == 6'd63) begin
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            rsel_d  = ~rsel;
            state_d = RD_IDLE;
          end else begin
            rpos_d  = nxt_pos;
            data_d  = bank_rdata;
            first_d = 1'b0;
            last_d  = (nxt_pos == 6'd63);
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Read FSM state and registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RD_IDLE;
      rpos      <= '0;
      rsel      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      rpos      <= rpos_d;
      rsel      <= rsel_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_first <= first_d;
      out_last  <= last_d;
    end
  end

`ifdef ZIGZAG_LAST_NZ_EN
  logic [NZ_W-1:0] nz_trk [2];
  logic [NZ_W-1:0] col_max;

  // Highest (zigzag position + 1) among the nonzero coefficients of the incoming column.
  always_comb begin
    col_max = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if ((in_data[(COL_W-1-COEF_W*r) -: COEF_W] != '0) &&
          (7'(7'(INV_ZZ[{3'(r), wcol}]) + 7'd1) > col_max)) begin
        col_max = 7'(7'(INV_ZZ[{3'(r), wcol}]) + 7'd1);
      end
    end
  end

  // Per-bank running maximum, restarted by the first column of each block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nz_trk[0] <= '0;
      nz_trk[1] <= '0;
    end else if (accept) begin
      if (wcol == 3'd0 || col_max > nz_trk[wsel]) nz_trk[wsel] <= col_max;
    end
  end

  // Latch the draining bank's value alongside position 0 and hold it for the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_last_nz <= '0;
    end else if (state == RD_IDLE && full[rsel]) begin
      out_last_nz <= nz_trk[rsel];
    end
  end
`endif

endmodule

// File: tb/tb_zigzag_buffer.sv
// Randomized self-checking bench for zigzag_buffer against a block/queue reference model.
module tb_zigzag_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_first;
  logic        out_last;
`ifdef ZIGZAG_LAST_NZ_EN
  logic [6:0]  out_last_nz;
`endif

  always #5 clk = ~clk;

  zigzag_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_first  (out_first),
`ifdef ZIGZAG_LAST_NZ_EN
    .out_last_nz(out_last_nz),
`endif
    .out_last   (out_last)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference model state
  int          cyc = 0;
  logic [5:0]  zz_ref [64];
  logic [7:0]  exp_q [$];
  int          done_q [$];
  int          lnz_q [$];
  logic [7:0]  got [$];
  int          lnz_log [$];
  logic [7:0]  cur_blk [64];
  int          nblk = 0, ncols = 0, rd_pos = 0, front_avail = 0, last_drain = 0;
  int          acc_cnt = 0;
  int          exp_v;
  int          rnd_ready = 0;
  int          stall_probe = 0, stall_at = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer back-pressure when enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = (rnd_ready != 0) ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Compare process: outputs are checked against the model every cycle, handshakes advance it.
  always @(negedge clk) begin : mon
    int m;
    if (!reset) begin
      exp_q.delete(); done_q.delete(); lnz_q.delete();
      nblk = 0; ncols = 0; rd_pos = 0; front_avail = 0; last_drain = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_first", int'(out_first), 0);
      chk("rst_out_last", int'(out_last), 0);
`ifdef ZIGZAG_LAST_NZ_EN
      chk("rst_out_last_nz", int'(out_last_nz), 0);
`endif
    end else begin
      exp_v = (nblk > 0 && cyc >= front_avail) ? 1 : 0;
      chk("out_valid", int'(out_valid), exp_v);
      chk("in_ready", int'(in_ready), (nblk < 2) ? 1 : 0);
      if (out_valid && exp_v != 0) begin
        chk("out_data", int'(out_data), int'(exp_q[0]));
        chk("out_first", int'(out_first), (rd_pos == 0) ? 1 : 0);
        chk("out_last", int'(out_last), (rd_pos == 63) ? 1 : 0);
`ifdef ZIGZAG_LAST_NZ_EN
        chk("out_last_nz", int'(out_last_nz), lnz_q[0]);
        if (out_ready && rd_pos == 0) lnz_log.push_back(int'(out_last_nz));
`endif
      end
      if (out_valid && out_ready && exp_v != 0) begin
        got.push_back(out_data);
        void'(exp_q.pop_front());
        rd_pos++;
        if (rd_pos == 64) begin
          rd_pos = 0;
          nblk--;
          void'(done_q.pop_front());
          void'(lnz_q.pop_front());
          last_drain = cyc + 1;
          if (nblk > 0) front_avail = imax(done_q[0], cyc + 1) + 1;
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        for (int r = 0; r < 8; r++) cur_blk[r*8 + ncols] = in_data[63-8*r -: 8];
        ncols++;
        if (ncols == 8) begin
          m = 0;
          for (int k = 0; k < 64; k++) begin
            exp_q.push_back(cur_blk[zz_ref[k]]);
            if (cur_blk[zz_ref[k]] != 8'd0) m = k + 1;
          end
          done_q.push_back(cyc + 1);
          lnz_q.push_back(m);
          nblk++;
          if (nblk == 1) front_avail = imax(cyc + 1, last_drain) + 1;
          ncols = 0;
        end
      end
    end
  end

  function automatic logic [63:0] col_of(input logic [7:0] b [64], input int c);
    logic [63:0] d;
    d = '0;
    for (int r = 0; r < 8; r++) d[63-8*r -: 8] = b[r*8 + c];
    return d;
  endfunction

  // Offer one column, wait (bounded) for acceptance; returns at posedge+1 with in_valid still high.
  task automatic send_col(input logic [63:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready && stall_probe != 0 && stall_at < 0) stall_at = acc_cnt;
    end while (!in_ready && n < 2000);
    if (n >= 2000) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_blk(input logic [7:0] b [64], input int gaps);
    for (int c = 0; c < 8; c++) begin
      if (gaps != 0 && ($urandom % 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_col(col_of(b, c));
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((nblk > 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", (n < 3000) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rnd_coef();
    case ($urandom % 6)
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  logic [7:0] blk [64];
  int         acc_edge, base, n, k, lo, hi;

  initial begin
    // zigzag order from diagonal traversal of the 8x8 grid
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ref[k] = 6'(r*8 + s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ref[k] = 6'(r*8 + s - r); k++; end
      end
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Ramp block: latency and zigzag sequence
    got.delete();
    for (int i = 0; i < 64; i++) blk[i] = 8'(i);
    for (int c = 0; c < 8; c++) send_col(col_of(blk, c));
    acc_edge = cyc;
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk("first_valid_latency", cyc - acc_edge, 1);
    wait_drain();
    chk("ramp_count", got.size(), 64);
    if (got.size() == 64) begin
      chk("ramp_pos0", int'(got[0]), 0);
      chk("ramp_pos1", int'(got[1]), 1);
      chk("ramp_pos2", int'(got[2]), 8);
      chk("ramp_pos3", int'(got[3]), 16);
      chk("ramp_pos4", int'(got[4]), 9);
      chk("ramp_pos10", int'(got[10]), 32);
      chk("ramp_pos35", int'(got[35]), 56);
      chk("ramp_pos63", int'(got[63]), 63);
    end

    // Three back-to-back blocks: writer stalls after 16 columns
    base = acc_cnt;
    stall_probe = 1;
    stall_at = -1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
      for (int c = 0; c < 8; c++) send_col(col_of(blk, c));
    end
    in_valid = 1'b0;
    stall_probe = 0;
    chk("cols_before_stall", stall_at - base, 16);
    chk("cols_total", acc_cnt - base, 24);
    wait_drain();

    // Random back-pressure and input gaps
    rnd_ready = 1;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 64; i++) blk[i] = rnd_coef();
      send_blk(blk, 1);
    end
    wait_drain();
    got.delete();
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
    blk[0] = 8'h80;
    blk[1] = 8'hFF;
    send_blk(blk, 1);
    wait_drain();
    rnd_ready = 0;
    chk("neg_count", got.size(), 64);
    if (got.size() == 64) begin
      chk("neg_80", int'(got[0]), 128);
      chk("neg_ff", int'(got[1]), 255);
    end

    // Reset after five columns
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
    for (int c = 0; c < 5; c++) send_col(col_of(blk, c));
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst5_in_ready", int'(in_ready), 1);
    chk("rst5_out_valid", int'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset mid-stream near position 30
    for (int i = 0; i < 64; i++) blk[i] = 8'(i | 1);
    send_blk(blk, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(nblk > 0 && rd_pos >= 30) && n < 200);
    chk("reach_pos30", (n < 200) ? 1 : 0, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rstmid_out_valid", int'(out_valid), 0);
    chk("rstmid_out_data", int'(out_data), 0);
    chk("rstmid_out_first", int'(out_first), 0);
    chk("rstmid_out_last", int'(out_last), 0);
    chk("rstmid_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    got.delete();
    for (int i = 0; i < 64; i++) blk[i] = 8'(i + 100);
    send_blk(blk, 0);
    wait_drain();
    chk("post_rst_count", got.size(), 64);
    if (got.size() == 64) begin
      chk("post_rst_pos0", int'(got[0]), 100);
      chk("post_rst_pos2", int'(got[2]), 108);
      chk("post_rst_pos63", int'(got[63]), 163);
    end

`ifdef ZIGZAG_LAST_NZ_EN
    // Last-nonzero tracking
    lnz_log.delete();
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    blk[17] = 8'hFD;
    send_blk(blk, 0);
    blk[17] = 8'h00;
    send_blk(blk, 0);
    blk[63] = 8'h01;
    send_blk(blk, 0);
    wait_drain();
    chk("lnz_count", lnz_log.size(), 3);
    if (lnz_log.size() == 3) begin
      chk("lnz_r2c1", lnz_log[0], 9);
      chk("lnz_zero", lnz_log[1], 0);
      chk("lnz_r7c7", lnz_log[2], 64);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
